// File: rtl/codec_i2c_cfg_sequencer.sv
// codec_i2c_cfg_sequencer: configures a WM8731 codec through its I2C control port.
// Walks a fixed table of 9-bit register writes. Each entry goes out as a 3-byte I2C
// write: {DEV_ADDR,W}, {reg,data[8]}, data[7:0]. Every bus state is split into 4
// quarters. Optional feature macro: CODEC_CFG_RETRY_EN. When it is defined, a NACKed
// entry is re-issued up to 3 times before the sequencer gives up.
module codec_i2c_cfg_sequencer #(
    parameter int         CLK_FREQ_HZ = 50_000_000,
    parameter int         I2C_FREQ_HZ = 100_000,
    parameter logic [6:0] DEV_ADDR    = 7'h1A,
    parameter int         NUM_REGS    = 11
) (
    input  logic       clk_clk,
    input  logic       reset_reset,
    input  logic       start,
    output logic       busy,
    output logic       codec_ready,
    output logic       error,
    output logic [3:0] cur_index,
    output logic       i2c_scl_o,
    output logic       i2c_sda_oe,
    input  logic       i2c_sda_i
);
    localparam int             QDIV = CLK_FREQ_HZ / (4 * I2C_FREQ_HZ);
    localparam int             QW   = $clog2(QDIV);
    localparam logic [QW-1:0]  QMAX = QW'(QDIV - 1);
    localparam logic [3:0]     LAST = 4'(NUM_REGS - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [QW-1:0]   r_qcnt;
    logic [1:0]      r_q;
    logic [2:0]      r_bit;
    logic [1:0]      r_byte;
    logic [3:0]      r_idx;
    logic            r_nack;
    logic            r_sda_s1, r_sda_s2;
    logic            r_scl, r_sda_oe;
    logic            w_busy, w_tick, w_qend, w_go, w_retry_ok;
    logic            w_scl, w_sda_oe, w_bitval;
    logic [15:0]     w_entry;
    logic [7:0]      w_byte;

    // Register table: {reg[6:0], data[8:0]}
    function automatic logic [15:0] cfg_entry(input logic [3:0] idx);
        case (idx)
            4'd0:    cfg_entry = {7'h0F, 9'h000};
            4'd1:    cfg_entry = {7'h00, 9'h017};
            4'd2:    cfg_entry = {7'h01, 9'h017};
            4'd3:    cfg_entry = {7'h02, 9'h079};
            4'd4:    cfg_entry = {7'h03, 9'h079};
            4'd5:    cfg_entry = {7'h04, 9'h012};
            4'd6:    cfg_entry = {7'h05, 9'h000};
            4'd7:    cfg_entry = {7'h06, 9'h000};
            4'd8:    cfg_entry = {7'h07, 9'h00A};
            4'd9:    cfg_entry = {7'h08, 9'h000};
            4'd10:   cfg_entry = {7'h09, 9'h001};
            default: cfg_entry = 16'h0000;
        endcase
    endfunction

    assign w_busy  = !(r_state == S_IDLE || r_state == S_DONE || r_state == S_ERR);
    assign w_tick  = w_busy && (r_qcnt == QMAX);
    assign w_qend  = w_tick && (r_q == 2'd3);
    assign w_go    = start && !w_busy;
    assign w_entry = cfg_entry(r_idx);

    // Select the byte currently on the wire, then the bit within it (MSB first)
    always_comb begin
        w_byte = w_entry[7:0];
        case (r_byte)
            2'd0:    w_byte = {DEV_ADDR, 1'b0};
            2'd1:    w_byte = {w_entry[15:9], w_entry[8]};
            default: w_byte = w_entry[7:0];
        endcase
        w_bitval = w_byte[r_bit];
    end

`ifdef CODEC_CFG_RETRY_EN
    logic [1:0] r_retry;
    // Count NACKed attempts of the current entry; a fresh entry starts from zero
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset)                    r_retry <= 2'd0;
        else if (w_go)                      r_retry <= 2'd0;
        else if (w_qend && r_state == S_GAP) r_retry <= r_nack ? r_retry + 2'd1 : 2'd0;
    end
    assign w_retry_ok = (r_retry != 2'd3);
`else
    assign w_retry_ok = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) r_state <= S_IDLE;
        else             r_state <= w_state_nxt;
    end

    // Next state plus the per-quarter SCL/SDA waveform of each bus state
    always_comb begin
        w_state_nxt = r_state;
        w_scl       = 1'b1;
        w_sda_oe    = 1'b0;
        case (r_state)
            S_IDLE, S_DONE, S_ERR: if (w_go) w_state_nxt = S_START;
            S_START: begin
                w_scl    = (r_q != 2'd3);
                w_sda_oe = r_q[1];
                if (w_qend) w_state_nxt = S_BIT;
            end
            S_BIT: begin
                w_scl    = (r_q == 2'd1) || (r_q == 2'd2);
                w_sda_oe = ~w_bitval;
                if (w_qend) w_state_nxt = (r_bit == 3'd0) ? S_ACK : S_BIT;
            end
            S_ACK: begin
                w_scl = (r_q == 2'd1) || (r_q == 2'd2);
                if (w_qend) w_state_nxt = (r_nack || r_byte == 2'd2) ? S_STOP : S_BIT;
            end
            S_STOP: begin
                w_scl    = (r_q != 2'd0);
                w_sda_oe = (r_q != 2'd3);
                if (w_qend) w_state_nxt = (r_nack && !w_retry_ok) ? S_ERR : S_GAP;
            end
            S_GAP: if (w_qend) w_state_nxt = (r_nack || r_idx != LAST) ? S_START : S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Quarter timing, bit/byte/entry counters, ACK sampling and registered pin drivers
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            r_qcnt   <= '0;
            r_q      <= 2'd0;
            r_bit    <= 3'd7;
            r_byte   <= 2'd0;
            r_idx    <= 4'd0;
            r_nack   <= 1'b0;
            r_sda_s1 <= 1'b1;
            r_sda_s2 <= 1'b1;
            r_scl    <= 1'b1;
            r_sda_oe <= 1'b0;
        end else begin
            r_sda_s1 <= i2c_sda_i;
            r_sda_s2 <= r_sda_s1;
            r_scl    <= w_scl;
            r_sda_oe <= w_sda_oe;
            if (!w_busy || w_tick) r_qcnt <= '0;
            else                   r_qcnt <= r_qcnt + 1'b1;
            if (!w_busy)     r_q <= 2'd0;
            else if (w_tick) r_q <= r_q + 2'd1;
            if (w_go) begin
                r_idx  <= 4'd0;
                r_nack <= 1'b0;
            end
            // ACK bit sampled at the end of q2, while SCL is high
            if (r_state == S_ACK && w_tick && r_q == 2'd2) r_nack <= r_sda_s2;
            if (w_qend) begin
                case (r_state)
                    S_START: begin
                        r_bit  <= 3'd7;
                        r_byte <= 2'd0;
                        r_nack <= 1'b0;
                    end
                    S_BIT: r_bit <= r_bit - 3'd1;
                    S_ACK: begin
                        r_bit <= 3'd7;
                        if (r_byte != 2'd2) r_byte <= r_byte + 2'd1;
                    end
                    S_GAP: if (!r_nack && r_idx != LAST) r_idx <= r_idx + 4'd1;
                    default: ;
                endcase
            end
        end
    end

    assign busy        = w_busy;
    assign codec_ready = (r_state == S_DONE);
    assign error       = (r_state == S_ERR);
    assign cur_index   = r_idx;
    assign i2c_scl_o   = r_scl;
    assign i2c_sda_oe  = r_sda_oe;
endmodule

// File: tb/tb_codec_i2c_cfg_sequencer.sv
// Bench for codec_i2c_cfg_sequencer: QDIV=4, behavioural I2C slave on SDA that
// decodes frames and ACKs/NACKs on demand.
module tb_codec_i2c_cfg_sequencer;
    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic       start = 1'b0;
    logic       busy, codec_ready, error, i2c_scl_o, i2c_sda_oe, i2c_sda_i;
    logic [3:0] cur_index;

    int checks = 0;
    int failures = 0;

    // slave model state
    logic       s_pull = 1'b0;
    logic       p_scl = 1'b1, p_sda = 1'b1, ackph = 1'b0, fr_nacked = 1'b0;
    logic [7:0] sh = 8'h00;
    int         bitcnt = 0, bytecnt = 0, n_start = 0, n_stop = 0, n_full = 0;
    int         nk_lo = 99, nk_hi = 99, nk_byte = 0;
    logic [7:0] fb [0:31][0:2];

    codec_i2c_cfg_sequencer #(
        .CLK_FREQ_HZ(400), .I2C_FREQ_HZ(25), .DEV_ADDR(7'h1A), .NUM_REGS(11)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .start(start), .busy(busy),
        .codec_ready(codec_ready), .error(error), .cur_index(cur_index),
        .i2c_scl_o(i2c_scl_o), .i2c_sda_oe(i2c_sda_oe), .i2c_sda_i(i2c_sda_i)
    );

    assign i2c_sda_i = !(i2c_sda_oe || s_pull);

    always #5 clk_clk = ~clk_clk;

    // Slave: decode START/STOP, shift bits on SCL rise, drive ACK after 8th bit
    always @(negedge clk_clk) begin
        logic scl, sda;
        int fr;
        scl = i2c_scl_o;
        sda = ~i2c_sda_oe;
        if (reset_reset || (start && !busy)) begin
            s_pull = 1'b0; ackph = 1'b0; bitcnt = 0; bytecnt = 0;
            n_start = 0; n_stop = 0; n_full = 0;
        end else if (p_scl && scl && p_sda && !sda) begin
            n_start++; bitcnt = 0; bytecnt = 0; ackph = 1'b0; fr_nacked = 1'b0;
        end else if (p_scl && scl && !p_sda && sda) begin
            n_stop++;
            if (bytecnt == 3 && !fr_nacked) n_full++;
        end else if (!p_scl && scl && !ackph) begin
            sh = {sh[6:0], sda}; bitcnt++;
        end else if (p_scl && !scl) begin
            if (ackph) begin
                ackph = 1'b0; s_pull = 1'b0; bytecnt++;
            end else if (bitcnt == 8) begin
                bitcnt = 0; ackph = 1'b1; fr = n_start - 1;
                if (fr >= 0 && fr < 32 && bytecnt < 3) fb[fr][bytecnt] = sh;
                if (fr >= nk_lo && fr <= nk_hi && bytecnt == nk_byte) begin
                    s_pull = 1'b0; fr_nacked = 1'b1;
                end else s_pull = 1'b1;
            end
        end
        p_scl = scl;
        p_sda = sda;
    end

    task automatic pulse_start();
        @(posedge clk_clk); #1 start = 1'b1;
        @(posedge clk_clk); #1 start = 1'b0;
    endtask

    task automatic wait_end(output int n, output bit ok);
        n = 0; ok = 1'b0;
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk_clk); #1; n++;
            if (codec_ready || error) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        repeat (3) @(posedge clk_clk);
        #1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%0b exp=0", busy); end
        checks++; if (codec_ready !== 1'b0 || error !== 1'b0) begin failures++; $display("FAIL rst_flags got=%0b%0b exp=00", codec_ready, error); end
        checks++; if (cur_index !== 4'd0) begin failures++; $display("FAIL rst_index got=%0d exp=0", cur_index); end
        checks++; if (i2c_scl_o !== 1'b1 || i2c_sda_oe !== 1'b0) begin failures++; $display("FAIL rst_bus got=%0b%0b exp=10", i2c_scl_o, i2c_sda_oe); end
        reset_reset = 1'b0;
        repeat (50) @(posedge clk_clk);
        #1;
        checks++; if (busy !== 1'b0 || n_start != 0 || i2c_scl_o !== 1'b1) begin failures++; $display("FAIL idle_stays got busy=%0b starts=%0d exp busy=0 starts=0", busy, n_start); end
    endtask

    task automatic test_full_run();
        int n; bit ok;
        nk_lo = 99; nk_hi = 99;
        pulse_start();
        checks++; if (busy !== 1'b1 || cur_index !== 4'd0) begin failures++; $display("FAIL run_busy got=%0b exp=1", busy); end
        wait_end(n, ok);
        checks++; if (!ok || codec_ready !== 1'b1 || error !== 1'b0) begin failures++; $display("FAIL run_ready got=%0b err=%0b exp=1/0", codec_ready, error); end
        checks++; if (n != 5280) begin failures++; $display("FAIL run_cycles got=%0d exp=5280", n); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL run_busy_fall got=%0b exp=0", busy); end
        checks++; if (n_full != 11 || n_start != 11 || n_stop != 11) begin failures++; $display("FAIL run_frames got=%0d/%0d/%0d exp=11/11/11", n_full, n_start, n_stop); end
        checks++; if ({fb[8][0], fb[8][1], fb[8][2]} !== 24'h340E0A) begin failures++; $display("FAIL entry8 got=%h exp=340e0a", {fb[8][0], fb[8][1], fb[8][2]}); end
        checks++; if ({fb[0][0], fb[0][1], fb[0][2]} !== 24'h341E00) begin failures++; $display("FAIL entry0 got=%h exp=341e00", {fb[0][0], fb[0][1], fb[0][2]}); end
        checks++; if ({fb[10][0], fb[10][1], fb[10][2]} !== 24'h341201) begin failures++; $display("FAIL entry10 got=%h exp=341201", {fb[10][0], fb[10][1], fb[10][2]}); end
        checks++; if ({fb[3][0], fb[3][1], fb[3][2]} !== 24'h340479) begin failures++; $display("FAIL entry3 got=%h exp=340479", {fb[3][0], fb[3][1], fb[3][2]}); end
    endtask

    task automatic test_reset_mid_byte();
        bit hit = 1'b0;
        pulse_start();
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk_clk); #1;
            if (cur_index == 4'd3 && bytecnt == 1 && bitcnt == 2 && !i2c_scl_o && i2c_sda_oe) begin hit = 1'b1; break; end
        end
        checks++; if (!hit) begin failures++; $display("FAIL midbyte_reach got=0 exp=1"); end
        reset_reset = 1'b1;
        #1;
        checks++; if (i2c_scl_o !== 1'b1 || i2c_sda_oe !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL midbyte_reset got scl=%0b oe=%0b busy=%0b exp 1/0/0", i2c_scl_o, i2c_sda_oe, busy); end
        repeat (3) @(posedge clk_clk);
        #1 reset_reset = 1'b0;
        repeat (40) @(posedge clk_clk);
        #1;
        checks++; if (busy !== 1'b0 || i2c_scl_o !== 1'b1 || i2c_sda_oe !== 1'b0 || cur_index !== 4'd0) begin failures++; $display("FAIL midbyte_idle got busy=%0b idx=%0d exp 0/0", busy, cur_index); end
    endtask

    task automatic test_back_to_back();
        int n = 0; bit pulsed = 1'b0, ok = 1'b0;
        nk_lo = 99; nk_hi = 99;
        pulse_start();
        for (int i = 0; i < 20000; i++) begin
            @(posedge clk_clk); #1; n++;
            if (start) start = 1'b0;
            else if (!pulsed && cur_index == 4'd2) begin start = 1'b1; pulsed = 1'b1; end
            if (codec_ready || error) begin ok = 1'b1; break; end
        end
        start = 1'b0;
        checks++; if (!ok || codec_ready !== 1'b1 || n != 5280) begin failures++; $display("FAIL busy_start got ready=%0b cycles=%0d exp 1/5280", codec_ready, n); end
        checks++; if (n_full != 11 || n_start != 11) begin failures++; $display("FAIL busy_start_frames got=%0d exp=11", n_full); end
    endtask

    task automatic test_nack();
        int n; bit ok; int exp_st;
        nk_lo = 5; nk_byte = 2;
`ifdef CODEC_CFG_RETRY_EN
        nk_hi = 8; exp_st = 9;
`else
        nk_hi = 5; exp_st = 6;
`endif
        pulse_start();
        wait_end(n, ok);
        checks++; if (!ok || error !== 1'b1 || codec_ready !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL nack_err got err=%0b rdy=%0b busy=%0b exp 1/0/0", error, codec_ready, busy); end
        checks++; if (cur_index !== 4'd5) begin failures++; $display("FAIL nack_index got=%0d exp=5", cur_index); end
        checks++; if (n_start != exp_st || n_stop != exp_st || n_full != 5) begin failures++; $display("FAIL nack_frames got=%0d/%0d/%0d exp=%0d/%0d/5", n_start, n_stop, n_full, exp_st, exp_st); end
        nk_lo = 99; nk_hi = 99;
    endtask

    task automatic test_restart_after_err();
        int n; bit ok;
        @(posedge clk_clk); #1 start = 1'b1;
        @(posedge clk_clk); #1 start = 1'b0;
        checks++; if (error !== 1'b0 || busy !== 1'b1 || cur_index !== 4'd0) begin failures++; $display("FAIL restart got err=%0b busy=%0b idx=%0d exp 0/1/0", error, busy, cur_index); end
        wait_end(n, ok);
        checks++; if (!ok || codec_ready !== 1'b1 || n_full != 11 || {fb[0][0], fb[0][1]} !== 16'h341E) begin failures++; $display("FAIL restart_run got rdy=%0b frames=%0d exp 1/11", codec_ready, n_full); end
    endtask

`ifdef CODEC_CFG_RETRY_EN
    task automatic test_retry();
        int n; bit ok;
        nk_lo = 4; nk_hi = 5; nk_byte = 0;
        pulse_start();
        wait_end(n, ok);
        checks++; if (!ok || codec_ready !== 1'b1 || n_start != 13 || n_full != 11) begin failures++; $display("FAIL retry_ok got rdy=%0b starts=%0d full=%0d exp 1/13/11", codec_ready, n_start, n_full); end
        checks++; if ({fb[6][0], fb[6][1], fb[6][2]} !== 24'h340679 || fb[5][0] !== 8'h34) begin failures++; $display("FAIL retry_bytes got=%h exp=340679", {fb[6][0], fb[6][1], fb[6][2]}); end
        nk_lo = 4; nk_hi = 7;
        pulse_start();
        wait_end(n, ok);
        checks++; if (!ok || error !== 1'b1 || cur_index !== 4'd4 || n_start != 8) begin failures++; $display("FAIL retry_err got err=%0b idx=%0d starts=%0d exp 1/4/8", error, cur_index, n_start); end
        nk_lo = 99; nk_hi = 99;
    endtask
`endif

    initial begin
        test_reset();
        test_full_run();
        test_reset_mid_byte();
        test_back_to_back();
        test_nack();
        test_restart_after_err();
`ifdef CODEC_CFG_RETRY_EN
        test_retry();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
